// File: rtl/alu_seq_if.sv
// Command and response handshake bundle between a host and the ALU sequencer.
// The host drives the master side; the sequencer implements the slave side.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [1:0]       cmd_sel;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_load, cmd_sel, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_sel, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_seq.sv
// Command sequencer for an external 4-bit NOT/OR/AND/XOR ALU.
// One command per handshake: IDLE -> EXEC -> RESP, result kept in an accumulator.
module alu_seq #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       sel_q;
    logic             load_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= ACC_INIT;
            b_q         <= '0;
            sel_q       <= 2'b00;
            load_q      <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        b_q         <= bus.cmd_b;
                        sel_q       <= bus.cmd_sel;
                        load_q      <= bus.cmd_load;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    acc_q       <= load_q ? b_q : alu_y;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // operands return to zero so the ALU sees 0/00 while idle
                    if (bus.rsp_ready) begin
                        cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        b_q         <= '0;
                        sel_q       <= 2'b00;
                        load_q      <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = acc_q;
    assign alu_a         = acc_q;
    assign alu_b         = b_q;
    assign alu_s         = sel_q;
    assign acc           = acc_q;
    assign op_count      = cnt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, transaction-level accumulator model
// and directed command vectors with literal expected results.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] alu_a, alu_b, alu_y, acc;
    logic [1:0] alu_s;
    logic [7:0] op_count;
    int         total = 0;
    int         bad = 0;
    bit         run = 1'b0;
    bit         rdy_idle = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(4)) bus ();

    alu_seq #(
        .WIDTH(4),
        .ACC_INIT(4'h0),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_s(alu_s),
        .alu_y(alu_y),
        .acc(acc),
        .op_count(op_count)
    );

    function automatic logic [3:0] alu_f(input logic [1:0] s,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        case (s)
            2'b00:   return ~a;
            2'b01:   return a | b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_y = alu_f(alu_s, alu_a, alu_b);

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Transaction model: a pending result becomes the accumulator one
    // cycle after acceptance; a queued result is the outstanding response.
    logic [3:0] acc_m = 4'h0;
    logic [7:0] cnt_m = 8'h0;
    logic [3:0] q[$];
    bit         pend = 1'b0;
    logic [3:0] pend_v = 4'h0;
    logic [3:0] b_m = 4'h0;
    logic [1:0] sel_m = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m = 4'h0;
            cnt_m = 8'h0;
            pend  = 1'b0;
            q.delete();
        end else if (pend) begin
            acc_m = pend_v;
            pend  = 1'b0;
        end else if (q.size() != 0) begin
            if (bus.rsp_ready) begin
                void'(q.pop_front());
                cnt_m = cnt_m + 8'd1;
            end
        end else if (bus.cmd_valid) begin
            b_m    = bus.cmd_b;
            sel_m  = bus.cmd_sel;
            pend_v = bus.cmd_load ? bus.cmd_b
                                  : alu_f(bus.cmd_sel, acc_m, bus.cmd_b);
            q.push_back(pend_v);
            pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run && rst_n) begin
            cmp("cmd_ready", bus.cmd_ready, q.size() == 0);
            cmp("rsp_valid", bus.rsp_valid, q.size() != 0 && !pend);
            cmp("acc", acc, acc_m);
            cmp("op_count", op_count, cnt_m);
            cmp("alu_a", alu_a, acc_m);
            if (q.size() == 0) begin
                cmp("alu_b_idle", alu_b, 4'h0);
                cmp("alu_s_idle", alu_s, 2'b00);
            end else if (pend) begin
                cmp("alu_b_exec", alu_b, b_m);
                cmp("alu_s_exec", alu_s, sel_m);
            end else begin
                cmp("rsp_data", bus.rsp_data, q[0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the response handshake.
    task automatic do_cmd(input bit ld, input logic [1:0] s,
                          input logic [3:0] b, input logic [3:0] exp,
                          input int hold);
        int k = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld;
        bus.cmd_sel   = s;
        bus.cmd_b     = b;
        while (!bus.cmd_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        cmp("accept_timeout", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        cmp("lat_exec", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        cmp("lat_resp", bus.rsp_valid, 1'b1);
        cmp("rsp_lit", bus.rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            cmp("bp_valid", bus.rsp_valid, 1'b1);
            cmp("bp_data", bus.rsp_data, exp);
            cmp("bp_ready", bus.cmd_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = rdy_idle;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_sel   = 2'b00;
        bus.cmd_b     = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;
        cmp("rst_cmd_ready", bus.cmd_ready, 1'b1);
        cmp("rst_rsp_valid", bus.rsp_valid, 1'b0);
        cmp("rst_acc", acc, 4'h0);
        cmp("rst_cnt", op_count, 8'd0);
        cmp("rst_alu_b", alu_b, 4'h0);
        cmp("rst_alu_s", alu_s, 2'b00);
        @(posedge clk);
        #1;

        do_cmd(1'b1, 2'b00, 4'hA, 4'hA, 0);
        do_cmd(1'b0, 2'b11, 4'h5, 4'hF, 0);
        cmp("cnt_two", op_count, 8'd2);
        do_cmd(1'b0, 2'b00, 4'h3, 4'h0, 0);
        do_cmd(1'b1, 2'b00, 4'hC, 4'hC, 0);
        do_cmd(1'b0, 2'b01, 4'h3, 4'hF, 0);
        do_cmd(1'b0, 2'b10, 4'h6, 4'h6, 0);
        do_cmd(1'b0, 2'b11, 4'h9, 4'hF, 5);
        cmp("cnt_seven", op_count, 8'd7);

        // asynchronous reset asserted between clock edges
        #1 rst_n = 1'b0;
        #1;
        cmp("async_acc", acc, 4'h0);
        cmp("async_rsp_valid", bus.rsp_valid, 1'b0);
        cmp("async_cnt", op_count, 8'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_cmd(1'b1, 2'b00, 4'h7, 4'h7, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_sel   = 2'b11;
        bus.cmd_b     = 4'h3;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        cmp("exec_busy", bus.cmd_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        cmp("exec_rst_acc", acc, 4'h0);
        cmp("exec_rst_valid", bus.rsp_valid, 1'b0);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            cmp("dropped_valid", bus.rsp_valid, 1'b0);
        end
        do_cmd(1'b0, 2'b01, 4'h2, 4'h2, 0);
        cmp("after_drop_cnt", op_count, 8'd1);

        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_idle      = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] v;
            v = i[3:0];
            do_cmd(1'b1, 2'b10, v, v, 0);
        end
        cmp("wrap_cnt", op_count, 8'd0);
        cmp("wrap_acc", acc, 4'hF);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
